scdata_decc_chk: RTL and testbench

- Read-path ECC check/correct stage directly downstream of the scdata control/IO stage.
- Consumes the 156-bit C6 read data, which is four 39-bit SEC-DED words: 32 data bits plus 7 check bits each.
- Produces corrected 128-bit data at C8 with per-word error flags.
- Maintains a sticky error log and saturating CE/UE counters that the sctag error-reporting logic reads.

---
 rtl/scdata_decc_chk_pkg.sv | 27 ++
 rtl/scdata_ecc39_chk.sv | 54 +++++
 rtl/scdata_decc_chk.sv | 194 +++++++++++++++++++
 tb/tb_scdata_decc_chk.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scdata_decc_chk_pkg.sv
// Shared constants for the scdata read-path SEC-DED check/correct stage.
package scdata_decc_chk_pkg;

  localparam int unsigned ECC_W  = 39;  // stored word: {data[31:0], chk[6:0]}
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CHK_W  = 7;
  localparam int unsigned HAM_W  = 6;   // Hamming check bits, chk[6] is overall parity
  localparam int unsigned SYN_W  = 7;   // {parity, syndrome[5:0]}

  // Highest occupied Hamming codeword position
  localparam logic [HAM_W-1:0] CW_MAX = 6'd38;

  // Log field widths
  localparam int unsigned SET_W  = 10;
  localparam int unsigned WAY_W  = 4;
  localparam int unsigned COL_W  = 2;
  localparam int unsigned WORD_W = 2;

  // Hamming position of data bit i (powers of two are reserved for check bits)
  localparam logic [HAM_W-1:0] DATA_POS [0:DATA_W-1] = '{
    6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
    6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

endpackage

// File: rtl/scdata_ecc39_chk.sv
// Combinational SEC-DED check of one 39-bit word: syndrome, classify, correct.
module scdata_ecc39_chk
  import scdata_decc_chk_pkg::*;
(
  input  logic [ECC_W-1:0]  word,
  output logic [DATA_W-1:0] data_cor,
  output logic [SYN_W-1:0]  syn,
  output logic              cerr,
  output logic              uerr
);

  logic [DATA_W-1:0] data;
  logic [HAM_W-1:0]  chk;
  logic [HAM_W-1:0]  recomp;
  logic [HAM_W-1:0]  s;
  logic              p;

  assign data = word[ECC_W-1:CHK_W];
  assign chk  = word[HAM_W-1:0];
  assign p    = ^word;
  assign s    = recomp ^ chk;
  assign syn  = {p, s};

  // Recompute the Hamming check bits from the received data
  always_comb begin
    recomp = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      for (int unsigned k = 0; k < HAM_W; k++) begin
        if (DATA_POS[i][k]) recomp[k] = recomp[k] ^ data[i];
      end
    end
  end

  // Classify the word and flip the data bit named by the syndrome on a CE
  always_comb begin
    cerr     = 1'b0;
    uerr     = 1'b0;
    data_cor = data;
    if (p) begin
      if (s <= CW_MAX) begin
        cerr = 1'b1;
        // s of zero or a power of two points at a check bit: data untouched
        for (int unsigned i = 0; i < DATA_W; i++) begin
          if (DATA_POS[i] == s) data_cor[i] = ~data[i];
        end
      end else begin
        uerr = 1'b1;
      end
    end else if (s != '0) begin
      uerr = 1'b1;
    end
  end

endmodule

// File: rtl/scdata_decc_chk.sv
// Read-path ECC stage: C6 capture, C7 check/correct, C8 output, error log and counters.
module scdata_decc_chk
  import scdata_decc_chk_pkg::*;
#(
  parameter int unsigned WORDS    = 4,
  parameter int unsigned CE_CNT_W = 16,
  parameter int unsigned UE_CNT_W = 8
) (
  input  logic                      rclk,
  input  logic                      arst,
  input  logic                      se,
  input  logic                      si,
  output logic                      so,
  input  logic [WORDS*ECC_W-1:0]    scdata_sctag_decc_c6,
  input  logic                      decc_vld_c6,
  input  logic [SET_W-1:0]          decc_set_c6,
  input  logic [WAY_W-1:0]          decc_way_c6,
  input  logic [COL_W-1:0]          decc_col_c6,
  input  logic                      ecc_chk_dis,
  input  logic                      err_log_clr,
  input  logic                      err_cnt_clr,
  output logic [WORDS*DATA_W-1:0]   decc_data_c8,
  output logic                      decc_vld_c8,
  output logic [WORDS-1:0]          decc_cerr_c8,
  output logic [WORDS-1:0]          decc_uerr_c8,
  output logic                      err_log_vld,
  output logic                      err_log_ue,
  output logic [SET_W-1:0]          err_log_set,
  output logic [WAY_W-1:0]          err_log_way,
  output logic [COL_W-1:0]          err_log_col,
  output logic [WORD_W-1:0]         err_log_word,
  output logic [SYN_W-1:0]          err_log_syn,
  output logic [CE_CNT_W-1:0]       ce_cnt,
  output logic [UE_CNT_W-1:0]       ue_cnt
);

  // Every flop lives in one packed struct so scan can shift it as a single chain
  typedef struct packed {
    logic [WORDS*ECC_W-1:0]  c7_raw;
    logic                    c7_vld;
    logic                    c7_dis;
    logic [SET_W-1:0]        c7_set;
    logic [WAY_W-1:0]        c7_way;
    logic [COL_W-1:0]        c7_col;
    logic [WORDS*DATA_W-1:0] c8_data;
    logic                    c8_vld;
    logic [WORDS-1:0]        c8_cerr;
    logic [WORDS-1:0]        c8_uerr;
    logic [SET_W-1:0]        c8_set;
    logic [WAY_W-1:0]        c8_way;
    logic [COL_W-1:0]        c8_col;
    logic [WORD_W-1:0]       c8_cand_word;
    logic [SYN_W-1:0]        c8_cand_syn;
    logic                    log_vld;
    logic                    log_ue;
    logic [SET_W-1:0]        log_set;
    logic [WAY_W-1:0]        log_way;
    logic [COL_W-1:0]        log_col;
    logic [WORD_W-1:0]       log_word;
    logic [SYN_W-1:0]        log_syn;
    logic [CE_CNT_W-1:0]     ce_cnt;
    logic [UE_CNT_W-1:0]     ue_cnt;
  } state_t;

  localparam int unsigned ST_W = $bits(state_t);

  state_t st;
  state_t nxt;

  logic [WORDS*DATA_W-1:0] cor_data;
  logic [WORDS*DATA_W-1:0] raw_data;
  logic [WORDS*SYN_W-1:0]  syn_all;
  logic [WORDS-1:0]        cerr_w;
  logic [WORDS-1:0]        uerr_w;
  logic [WORDS-1:0]        cerr_q;
  logic [WORDS-1:0]        uerr_q;
  logic [WORD_W-1:0]       cand_word;
  logic [SYN_W-1:0]        cand_syn;
  logic                    cand_c8;
  logic [CE_CNT_W:0]       ce_sum;
  logic [UE_CNT_W:0]       ue_sum;

  for (genvar w = 0; w < WORDS; w++) begin : g_word
    scdata_ecc39_chk u_chk (
      .word     (st.c7_raw[w*ECC_W +: ECC_W]),
      .data_cor (cor_data[w*DATA_W +: DATA_W]),
      .syn      (syn_all[w*SYN_W +: SYN_W]),
      .cerr     (cerr_w[w]),
      .uerr     (uerr_w[w])
    );
    assign raw_data[w*DATA_W +: DATA_W] = st.c7_raw[w*ECC_W+CHK_W +: DATA_W];
  end

  // Qualify C7 flags and pick the log candidate: lowest UE word, else lowest CE word
  always_comb begin
    cerr_q    = (st.c7_vld && !st.c7_dis) ? cerr_w : '0;
    uerr_q    = (st.c7_vld && !st.c7_dis) ? uerr_w : '0;
    cand_word = '0;
    cand_syn  = '0;
    // Descending scan so the lowest flagged index is the one left standing
    for (int unsigned i = WORDS; i > 0; i--) begin
      if (cerr_q[i-1]) begin
        cand_word = WORD_W'(i-1);
        cand_syn  = syn_all[(i-1)*SYN_W +: SYN_W];
      end
    end
    if (|uerr_q) begin
      for (int unsigned i = WORDS; i > 0; i--) begin
        if (uerr_q[i-1]) begin
          cand_word = WORD_W'(i-1);
          cand_syn  = syn_all[(i-1)*SYN_W +: SYN_W];
        end
      end
    end
  end

  // Next state for the pipeline, the sticky log and the saturating counters
  always_comb begin
    nxt     = st;
    cand_c8 = (|st.c8_cerr) || (|st.c8_uerr);
    ce_sum  = {1'b0, st.ce_cnt};
    ue_sum  = {1'b0, st.ue_cnt};

    nxt.c7_raw = scdata_sctag_decc_c6;
    nxt.c7_vld = decc_vld_c6;
    nxt.c7_dis = ecc_chk_dis;
    nxt.c7_set = decc_set_c6;
    nxt.c7_way = decc_way_c6;
    nxt.c7_col = decc_col_c6;

    nxt.c8_vld       = st.c7_vld;
    nxt.c8_cerr      = cerr_q;
    nxt.c8_uerr      = uerr_q;
    nxt.c8_set       = st.c7_set;
    nxt.c8_way       = st.c7_way;
    nxt.c8_col       = st.c7_col;
    nxt.c8_cand_word = cand_word;
    nxt.c8_cand_syn  = cand_syn;
    if (st.c7_vld) nxt.c8_data = st.c7_dis ? raw_data : cor_data;

    if (cand_c8 && (!st.log_vld || err_log_clr || ((|st.c8_uerr) && !st.log_ue))) begin
      nxt.log_vld  = 1'b1;
      nxt.log_ue   = |st.c8_uerr;
      nxt.log_set  = st.c8_set;
      nxt.log_way  = st.c8_way;
      nxt.log_col  = st.c8_col;
      nxt.log_word = st.c8_cand_word;
      nxt.log_syn  = st.c8_cand_syn;
    end else if (err_log_clr) begin
      nxt.log_vld  = 1'b0;
      nxt.log_ue   = 1'b0;
      nxt.log_set  = '0;
      nxt.log_way  = '0;
      nxt.log_col  = '0;
      nxt.log_word = '0;
      nxt.log_syn  = '0;
    end

    for (int unsigned i = 0; i < WORDS; i++) begin
      ce_sum = ce_sum + (CE_CNT_W+1)'(st.c8_cerr[i]);
      ue_sum = ue_sum + (UE_CNT_W+1)'(st.c8_uerr[i]);
    end
    if (err_cnt_clr) begin
      nxt.ce_cnt = '0;
      nxt.ue_cnt = '0;
    end else begin
      nxt.ce_cnt = ce_sum[CE_CNT_W] ? '1 : ce_sum[CE_CNT_W-1:0];
      nxt.ue_cnt = ue_sum[UE_CNT_W] ? '1 : ue_sum[UE_CNT_W-1:0];
    end
  end

  // State register: async reset, scan shift when se, functional update otherwise
  always_ff @(posedge rclk or posedge arst) begin
    if (arst)    st <= '0;
    else if (se) st <= {st[ST_W-2:0], si};
    else         st <= nxt;
  end

  assign so           = st[ST_W-1];
  assign decc_data_c8 = st.c8_data;
  assign decc_vld_c8  = st.c8_vld;
  assign decc_cerr_c8 = st.c8_cerr;
  assign decc_uerr_c8 = st.c8_uerr;
  assign err_log_vld  = st.log_vld;
  assign err_log_ue   = st.log_ue;
  assign err_log_set  = st.log_set;
  assign err_log_way  = st.log_way;
  assign err_log_col  = st.log_col;
  assign err_log_word = st.log_word;
  assign err_log_syn  = st.log_syn;
  assign ce_cnt       = st.ce_cnt;
  assign ue_cnt       = st.ue_cnt;

endmodule

// File: tb/tb_scdata_decc_chk.sv
// Self-checking bench for scdata_decc_chk: directed cases plus random traffic
// against a flip-set based reference model of the SEC-DED rules.
module tb_scdata_decc_chk;

  logic         rclk = 1'b0;
  logic         arst;
  logic         se, si, so;
  logic [155:0] scdata_sctag_decc_c6;
  logic         decc_vld_c6;
  logic [9:0]   decc_set_c6;
  logic [3:0]   decc_way_c6;
  logic [1:0]   decc_col_c6;
  logic         ecc_chk_dis, err_log_clr, err_cnt_clr;
  logic [127:0] decc_data_c8;
  logic         decc_vld_c8;
  logic [3:0]   decc_cerr_c8, decc_uerr_c8;
  logic         err_log_vld, err_log_ue;
  logic [9:0]   err_log_set;
  logic [3:0]   err_log_way;
  logic [1:0]   err_log_col;
  logic [1:0]   err_log_word;
  logic [6:0]   err_log_syn;
  logic [15:0]  ce_cnt;
  logic [7:0]   ue_cnt;

  always #5 rclk = ~rclk;

  scdata_decc_chk #(.WORDS(4), .CE_CNT_W(16), .UE_CNT_W(8)) dut (
    .rclk(rclk), .arst(arst), .se(se), .si(si), .so(so),
    .scdata_sctag_decc_c6(scdata_sctag_decc_c6), .decc_vld_c6(decc_vld_c6),
    .decc_set_c6(decc_set_c6), .decc_way_c6(decc_way_c6), .decc_col_c6(decc_col_c6),
    .ecc_chk_dis(ecc_chk_dis), .err_log_clr(err_log_clr), .err_cnt_clr(err_cnt_clr),
    .decc_data_c8(decc_data_c8), .decc_vld_c8(decc_vld_c8),
    .decc_cerr_c8(decc_cerr_c8), .decc_uerr_c8(decc_uerr_c8),
    .err_log_vld(err_log_vld), .err_log_ue(err_log_ue), .err_log_set(err_log_set),
    .err_log_way(err_log_way), .err_log_col(err_log_col), .err_log_word(err_log_word),
    .err_log_syn(err_log_syn), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt)
  );

  typedef struct {
    bit           vld;
    logic [127:0] data;
    logic [3:0]   ce;
    logic [3:0]   ue;
    logic [9:0]   set;
    logic [3:0]   way;
    logic [1:0]   col;
    logic [27:0]  syn;
  } rec_t;

  int unsigned  pos_of [32];
  rec_t         pipe_q[$];
  rec_t         prev;
  logic [127:0] hold_data;
  bit           m_vld, m_ue;
  logic [9:0]   m_set;
  logic [3:0]   m_way;
  logic [1:0]   m_col;
  logic [1:0]   m_word;
  logic [6:0]   m_syn;
  int unsigned  m_ce, m_uec;
  int unsigned  total = 0;
  int unsigned  passes = 0;
  logic [155:0] fm;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Hamming position of stored word bit b (overall parity sits at position 0)
  function automatic int unsigned wpos(input int unsigned b);
    if (b < 6) return 1 << b;
    if (b == 6) return 0;
    return pos_of[b-7];
  endfunction

  // Check bits chosen so the XOR of all set positions is zero, then overall parity
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [5:0] c = '0;
    for (int i = 0; i < 32; i++) if (d[i]) c ^= 6'(pos_of[i]);
    return {d, ^{d, c}, c};
  endfunction

  task automatic model_reset();
    rec_t z;
    z.vld = 0; z.data = '0; z.ce = '0; z.ue = '0; z.set = '0; z.way = '0; z.col = '0; z.syn = '0;
    pipe_q.delete();
    pipe_q.push_back(z);
    prev = z;
    hold_data = '0;
    m_vld = 0; m_ue = 0; m_set = '0; m_way = '0; m_col = '0; m_word = '0; m_syn = '0;
    m_ce = 0; m_uec = 0;
  endtask

  task automatic model_update(input rec_t c, input bit lclr, input bit cclr);
    int  cidx = 0;
    bit  cue  = (c.ue != 0);
    bit  any  = (c.ue != 0) || (c.ce != 0);
    for (int i = 3; i >= 0; i--) if (cue ? c.ue[i] : c.ce[i]) cidx = i;
    if (any && (!m_vld || lclr || (cue && !m_ue))) begin
      m_vld = 1; m_ue = cue; m_set = c.set; m_way = c.way; m_col = c.col;
      m_word = cidx[1:0]; m_syn = c.syn[7*cidx +: 7];
    end else if (lclr) begin
      m_vld = 0; m_ue = 0; m_set = '0; m_way = '0; m_col = '0; m_word = '0; m_syn = '0;
    end
    if (cclr) begin
      m_ce = 0; m_uec = 0;
    end else begin
      m_ce  = m_ce + $countones(c.ce);
      m_uec = m_uec + $countones(c.ue);
      if (m_ce > 65535) m_ce = 65535;
      if (m_uec > 255) m_uec = 255;
    end
  endtask

  // Drive one C6 access, clock it, then check C8 outputs, log and counters
  task automatic send(input bit vld, input bit dis, input logic [9:0] set, input logic [3:0] way,
                      input logic [1:0] col, input logic [127:0] data, input logic [155:0] flips,
                      input bit lclr, input bit cclr);
    rec_t         r, c;
    logic [155:0] cw;
    r.vld = vld; r.set = set; r.way = way; r.col = col; r.ce = '0; r.ue = '0; r.syn = '0;
    for (int w = 0; w < 4; w++) begin
      logic [38:0] word;
      logic [31:0] cor;
      int unsigned s = 0;
      bit          p = 0;
      bit          is_ce = 0, is_ue = 0;
      word = enc(data[32*w +: 32]) ^ flips[39*w +: 39];
      for (int b = 0; b < 39; b++) if (flips[39*w+b]) begin s ^= wpos(b); p = ~p; end
      cor = word[38:7];
      if (p && s <= 38) begin
        is_ce = 1;
        for (int i = 0; i < 32; i++) if (pos_of[i] == s) cor[i] = ~cor[i];
      end else if (p || s != 0) begin
        is_ue = 1;
      end
      cw[39*w +: 39] = word;
      r.data[32*w +: 32] = dis ? word[38:7] : cor;
      r.ce[w] = vld && !dis && is_ce;
      r.ue[w] = vld && !dis && is_ue;
      r.syn[7*w +: 7] = {p, 6'(s)};
    end
    scdata_sctag_decc_c6 = cw; decc_vld_c6 = vld; ecc_chk_dis = dis;
    decc_set_c6 = set; decc_way_c6 = way; decc_col_c6 = col;
    err_log_clr = lclr; err_cnt_clr = cclr;
    pipe_q.push_back(r);
    @(posedge rclk);
    #1;
    model_update(prev, lclr, cclr);
    chk("log_vld",  128'(err_log_vld),  128'(m_vld));
    chk("log_ue",   128'(err_log_ue),   128'(m_ue));
    chk("log_set",  128'(err_log_set),  128'(m_set));
    chk("log_way",  128'(err_log_way),  128'(m_way));
    chk("log_col",  128'(err_log_col),  128'(m_col));
    chk("log_word", 128'(err_log_word), 128'(m_word));
    chk("log_syn",  128'(err_log_syn),  128'(m_syn));
    chk("ce_cnt",   128'(ce_cnt),       128'(m_ce));
    chk("ue_cnt",   128'(ue_cnt),       128'(m_uec));
    c = pipe_q.pop_front();
    if (c.vld) hold_data = c.data;
    chk("vld_c8",  128'(decc_vld_c8),  128'(c.vld));
    chk("data_c8", decc_data_c8,       hold_data);
    chk("cerr_c8", 128'(decc_cerr_c8), 128'(c.ce));
    chk("uerr_c8", 128'(decc_uerr_c8), 128'(c.ue));
    prev = c;
  endtask

  task automatic idle(input bit lclr, input bit cclr);
    send(0, 0, '0, '0, '0, '0, '0, lclr, cclr);
  endtask

  task automatic rand_flips(output logic [155:0] f, input int fixed);
    f = '0;
    for (int w = 0; w < 4; w++) begin
      int n, r;
      r = int'($urandom_range(0, 99));
      n = (fixed >= 0) ? fixed : (r < 50 ? 0 : (r < 85 ? 1 : 2));
      for (int k = 0; k < n; k++) begin
        int b;
        do b = int'($urandom_range(0, 38)); while (f[39*w+b]);
        f[39*w+b] = 1'b1;
      end
    end
  endtask

  function automatic logic [127:0] rdata();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_vld"},   128'(decc_vld_c8),  '0);
    chk({tag, "_data"},  decc_data_c8,       '0);
    chk({tag, "_cerr"},  128'(decc_cerr_c8), '0);
    chk({tag, "_uerr"},  128'(decc_uerr_c8), '0);
    chk({tag, "_logv"},  128'(err_log_vld),  '0);
    chk({tag, "_logue"}, 128'(err_log_ue),   '0);
    chk({tag, "_logset"},128'(err_log_set),  '0);
    chk({tag, "_logsyn"},128'(err_log_syn),  '0);
    chk({tag, "_ce"},    128'(ce_cnt),       '0);
    chk({tag, "_ue"},    128'(ue_cnt),       '0);
  endtask

  initial begin
    int unsigned p = 2;
    for (int i = 0; i < 32; i++) begin
      p++;
      while (is_pow2(p)) p++;
      pos_of[i] = p;
    end

    arst = 1; se = 0; si = 0;
    scdata_sctag_decc_c6 = '0; decc_vld_c6 = 0; decc_set_c6 = '0; decc_way_c6 = '0;
    decc_col_c6 = '0; ecc_chk_dis = 0; err_log_clr = 0; err_cnt_clr = 0;
    repeat (2) @(posedge rclk);
    #1;
    check_all_zero("reset");
    @(negedge rclk);
    arst = 0;
    model_reset();

    // All-zero codewords back to back
    for (int i = 0; i < 100; i++) send(1, 0, 10'(i), 4'(i), 2'(i), '0, '0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    chk("zero_ce", 128'(ce_cnt), '0);
    chk("zero_ue", 128'(ue_cnt), '0);

    // Word 0 data[0] flipped: CE at position 3
    fm = '0; fm[7] = 1'b1;
    send(1, 0, 10'h001, 4'h3, 2'h1, '0, fm, 0, 0);
    idle(0, 0);
    chk("ce0_flags", 128'(decc_cerr_c8), 128'(4'b0001));
    chk("ce0_data",  decc_data_c8, '0);
    idle(0, 0);
    chk("ce0_logv", 128'(err_log_vld), 128'(1'b1));
    chk("ce0_logue", 128'(err_log_ue), '0);
    chk("ce0_word", 128'(err_log_word), '0);
    chk("ce0_syn", 128'(err_log_syn), 128'(7'h43));
    chk("ce0_cnt", 128'(ce_cnt), 128'(16'd1));

    // Word 2 double data-bit error overwrites the logged CE
    fm = '0; fm[85] = 1'b1; fm[86] = 1'b1;
    send(1, 0, 10'h002, 4'h5, 2'h2, '0, fm, 0, 0);
    idle(0, 0);
    chk("ue2_flags", 128'(decc_uerr_c8), 128'(4'b0100));
    chk("ue2_data", decc_data_c8, 128'h3 << 64);
    idle(0, 0);
    chk("ue2_logue", 128'(err_log_ue), 128'(1'b1));
    chk("ue2_word", 128'(err_log_word), 128'(2'd2));
    chk("ue2_cnt", 128'(ue_cnt), 128'(8'd1));

    // CE never overwrites a CE; clear coincident with a new CE loads the new one
    idle(1, 0);
    chk("clr_logv", 128'(err_log_vld), '0);
    fm = '0; fm[7] = 1'b1;
    send(1, 0, 10'h001, 4'h1, 2'h0, '0, fm, 0, 0);
    send(1, 0, 10'h155, 4'h2, 2'h1, '0, fm, 0, 0);
    idle(0, 0);
    idle(0, 0);
    chk("ce_keep_set", 128'(err_log_set), 128'(10'h001));
    send(1, 0, 10'h0AA, 4'h4, 2'h3, '0, fm, 0, 0);
    idle(0, 0);
    idle(1, 0);
    chk("clr_new_set", 128'(err_log_set), 128'(10'h0AA));
    chk("clr_new_vld", 128'(err_log_vld), 128'(1'b1));

    // Triple flip giving p=1 with s=49 on word 1
    fm = '0; fm[39] = 1'b1; fm[43] = 1'b1; fm[44] = 1'b1;
    send(1, 0, 10'h010, 4'h0, 2'h0, '0, fm, 0, 0);
    idle(0, 0);
    chk("s49_uerr", 128'(decc_uerr_c8), 128'(4'b0010));
    idle(0, 0);

    // Check disabled: raw data, no flags
    fm = '0; fm[39*3+7] = 1'b1;
    send(1, 1, 10'h020, 4'h0, 2'h0, '0, fm, 0, 0);
    idle(0, 0);
    chk("dis_cerr", 128'(decc_cerr_c8), '0);
    chk("dis_data", decc_data_c8, 128'h1 << 96);
    idle(0, 0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rand_flips(fm, -1);
      send($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, 10'($urandom), 4'($urandom),
           2'($urandom), rdata(), fm, $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
    end

    // CE counter saturation
    idle(0, 0);
    idle(0, 0);
    idle(0, 1);
    chk("cnt_clr", 128'(ce_cnt), '0);
    for (int i = 0; i < 16383; i++) begin
      rand_flips(fm, 1);
      send(1, 0, 10'($urandom), 4'($urandom), 2'($urandom), rdata(), fm, 0, 0);
    end
    fm = '0; fm[7] = 1'b1; fm[39+20] = 1'b1;
    send(1, 0, 10'h0, 4'h0, 2'h0, rdata(), fm, 0, 0);
    idle(0, 0);
    idle(0, 0);
    chk("ce_fffe", 128'(ce_cnt), 128'(16'hFFFE));
    for (int i = 0; i < 2; i++) begin
      rand_flips(fm, 1);
      send(1, 0, 10'h0, 4'h0, 2'h0, rdata(), fm, 0, 0);
    end
    idle(0, 0);
    idle(0, 0);
    chk("ce_sat", 128'(ce_cnt), 128'(16'hFFFF));
    rand_flips(fm, 1);
    send(1, 0, 10'h0, 4'h0, 2'h0, rdata(), fm, 0, 0);
    idle(0, 0);
    idle(0, 0);
    chk("ce_hold", 128'(ce_cnt), 128'(16'hFFFF));
    rand_flips(fm, 1);
    send(1, 0, 10'h0, 4'h0, 2'h0, rdata(), fm, 0, 0);
    idle(0, 0);
    idle(0, 1);
    chk("ce_clr_drop", 128'(ce_cnt), '0);

    // UE counter saturation
    for (int i = 0; i < 64; i++) begin
      rand_flips(fm, 2);
      send(1, 0, 10'($urandom), 4'($urandom), 2'($urandom), rdata(), fm, 0, 0);
    end
    idle(0, 0);
    idle(0, 0);
    chk("ue_sat", 128'(ue_cnt), 128'(8'hFF));

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      rand_flips(fm, 1);
      send(1, 0, 10'($urandom), 4'($urandom), 2'($urandom), rdata(), fm, 0, 0);
    end
    #2;
    arst = 1;
    #1;
    check_all_zero("arst");
    @(posedge rclk);
    @(negedge rclk);
    arst = 0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      rand_flips(fm, -1);
      send(1, 0, 10'($urandom), 4'($urandom), 2'($urandom), rdata(), fm, 0, 0);
    end
    idle(0, 0);
    idle(0, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
